// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: ALU opcodes, forwarding-source selects and the ID/EX entry layout.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        AND = 3'b100,
        OR  = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MWB = 2'd1,
        FWD_EXM = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [2:0]        alu_cntrl;
        logic              alu_src;
        logic              reg_write;
        logic              is_load;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side and execute-side handshake channels of the ID/EX stage.
interface id_ex_stage_if #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_rs1_data;
    logic [WIDTH-1:0]  in_rs2_data;
    logic [WIDTH-1:0]  in_imm;
    logic [REG_AW-1:0] in_rs1;
    logic [REG_AW-1:0] in_rs2;
    logic [REG_AW-1:0] in_rd;
    logic [2:0]        in_alu_cntrl;
    logic              in_alu_src;
    logic              in_reg_write;
    logic              in_is_load;

    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_a;
    logic [WIDTH-1:0]  out_b;
    logic [WIDTH-1:0]  out_store_data;
    logic [2:0]        out_alu_cntrl;
    logic [REG_AW-1:0] out_rd;
    logic              out_reg_write;
    logic              out_is_load;

    modport master (
        output in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
               in_alu_cntrl, in_alu_src, in_reg_write, in_is_load, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_store_data, out_alu_cntrl,
               out_rd, out_reg_write, out_is_load
    );

    modport slave (
        input  in_valid, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd,
               in_alu_cntrl, in_alu_src, in_reg_write, in_is_load, out_ready,
        output in_ready, out_valid, out_a, out_b, out_store_data, out_alu_cntrl,
               out_rd, out_reg_write, out_is_load
    );

endinterface

// File: rtl/id_ex_stage_forward_mux.sv
// Operand forwarding mux: EX/MEM beats MEM/WB beats the register-file value; x0 is never forwarded.
module forward_mux #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0]   rs,
    input  logic [WIDTH-1:0]    reg_data,
    input  logic [REG_AW-1:0]   exm_rd,
    input  logic                exm_reg_write,
    input  logic [WIDTH-1:0]    exm_result,
    input  logic [REG_AW-1:0]   mwb_rd,
    input  logic                mwb_reg_write,
    input  logic [WIDTH-1:0]    mwb_result,
    output logic [WIDTH-1:0]    data,
    output riscv_pkg::fwd_sel_e sel
);
    import riscv_pkg::*;

    logic exm_hit;
    logic mwb_hit;

    assign exm_hit = exm_reg_write && (exm_rd != '0) && (exm_rd == rs);
    assign mwb_hit = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs);

    always_comb begin
        sel  = FWD_REG;
        data = reg_data;
        if (exm_hit) begin
            sel  = FWD_EXM;
            data = exm_result;
        end else if (mwb_hit) begin
            sel  = FWD_MWB;
            data = mwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush, operand forwarding and load-use hold.
// Build option ID_EX_FORWARD_EN: forward from EX/MEM and MEM/WB; when undefined, any RAW match stalls.
module id_ex_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    id_ex_stage_if.slave      bus,
    input  logic              flush,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic              exm_is_load,
    input  logic [WIDTH-1:0]  exm_result,
    input  logic [REG_AW-1:0] mwb_rd,
    input  logic              mwb_reg_write,
    input  logic [WIDTH-1:0]  mwb_result
);
    import riscv_pkg::*;

    id_ex_t           in_entry;
    id_ex_t           entry_p1;
    logic             vld_p1;
    logic             hold;
    logic             fire;
    logic             accept;
    logic [WIDTH-1:0] rs1_fwd;
    logic [WIDTH-1:0] rs2_fwd;

    function automatic logic src_hit(input logic wr, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return wr && (rd != '0) && (rd == rs);
    endfunction

    always_comb begin
        in_entry           = '0;
        in_entry.rs1_data  = bus.in_rs1_data;
        in_entry.rs2_data  = bus.in_rs2_data;
        in_entry.imm       = bus.in_imm;
        in_entry.rs1       = bus.in_rs1;
        in_entry.rs2       = bus.in_rs2;
        in_entry.rd        = bus.in_rd;
        in_entry.alu_cntrl = bus.in_alu_cntrl;
        in_entry.alu_src   = bus.in_alu_src;
        in_entry.reg_write = bus.in_reg_write;
        in_entry.is_load   = bus.in_is_load;
    end

    assign bus.out_valid = vld_p1 & ~hold;
    assign fire          = bus.out_valid & bus.out_ready;
    assign bus.in_ready  = flush | ~vld_p1 | fire;
    assign accept        = bus.in_valid & bus.in_ready & ~flush;

    // Stage p1: the single held ID/EX entry; flush wins over accept and drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            entry_p1 <= '0;
        end else if (flush) begin
            vld_p1   <= 1'b0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            entry_p1 <= in_entry;
        end else if (fire) begin
            vld_p1   <= 1'b0;
        end
    end

`ifdef ID_EX_FORWARD_EN
    fwd_sel_e rs1_sel;
    fwd_sel_e rs2_sel;
    logic     unused_sel;

    forward_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs            (entry_p1.rs1),
        .reg_data      (entry_p1.rs1_data),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .mwb_rd        (mwb_rd),
        .mwb_reg_write (mwb_reg_write),
        .mwb_result    (mwb_result),
        .data          (rs1_fwd),
        .sel           (rs1_sel)
    );

    forward_mux #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs            (entry_p1.rs2),
        .reg_data      (entry_p1.rs2_data),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .mwb_rd        (mwb_rd),
        .mwb_reg_write (mwb_reg_write),
        .mwb_result    (mwb_result),
        .data          (rs2_fwd),
        .sel           (rs2_sel)
    );

    assign unused_sel = ^{rs1_sel, rs2_sel};

    // A load result is not available until MEM/WB, so a consumer in EX/MEM must wait one cycle.
    assign hold = exm_is_load &
                  (src_hit(exm_reg_write, exm_rd, entry_p1.rs1) |
                   (~entry_p1.alu_src & src_hit(exm_reg_write, exm_rd, entry_p1.rs2)));
`else
    logic unused_fwd;

    assign rs1_fwd = entry_p1.rs1_data;
    assign rs2_fwd = entry_p1.rs2_data;

    // rs2 is always checked because it feeds store data even when B takes the immediate.
    assign hold = src_hit(exm_reg_write, exm_rd, entry_p1.rs1) |
                  src_hit(exm_reg_write, exm_rd, entry_p1.rs2) |
                  src_hit(mwb_reg_write, mwb_rd, entry_p1.rs1) |
                  src_hit(mwb_reg_write, mwb_rd, entry_p1.rs2);

    assign unused_fwd = ^{exm_result, mwb_result, exm_is_load};
`endif

    assign bus.out_a          = rs1_fwd;
    assign bus.out_b          = entry_p1.alu_src ? entry_p1.imm : rs2_fwd;
    assign bus.out_store_data = rs2_fwd;
    assign bus.out_alu_cntrl  = vld_p1 ? entry_p1.alu_cntrl : 3'b000;
    assign bus.out_rd         = vld_p1 ? entry_p1.rd : '0;
    assign bus.out_reg_write  = vld_p1 & entry_p1.reg_write;
    assign bus.out_is_load    = vld_p1 & entry_p1.is_load;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage for the RISC-V core: a one-entry ID/EX register with valid/ready handshake, flush, operand forwarding and load-use hold. It sits directly upstream of the 32-bit ALU and drives that ALU's `a`, `b` and `alu_cntrl` inputs each cycle. Forwarded values come from the EX/MEM and MEM/WB stages.

## Interface
- `WIDTH`, 32, datapath width.
- `REG_AW`, 5, register-index width.
- `clk` in 1, rising-edge clock.
- `rst_n` in 1, asynchronous active-low reset.
- `in_valid` in 1, decode presents an instruction.
- `in_ready` out 1, stage accepts this cycle.
- `in_rs1_data`, `in_rs2_data`, `in_imm` in WIDTH, register-file reads and immediate.
- `in_rs1`, `in_rs2`, `in_rd` in REG_AW, register indices.
- `in_alu_cntrl` in 3, ALU opcode.
- `in_alu_src` in 1, 1 selects `imm` for B.
- `in_reg_write`, `in_is_load` in 1, destination write and load flags.
- `flush` in 1, squash held and incoming instruction.
- `exm_rd` in REG_AW, `exm_reg_write` in 1, `exm_is_load` in 1, `exm_result` in WIDTH: EX/MEM forwarding source.
- `mwb_rd` in REG_AW, `mwb_reg_write` in 1, `mwb_result` in WIDTH: MEM/WB forwarding source.
- `out_valid` out 1, EX operands valid.
- `out_ready` in 1, EX consumes.
- `out_a`, `out_b`, `out_store_data` out WIDTH, ALU operands and store data.
- `out_alu_cntrl` out 3, `out_rd` out REG_AW, `out_reg_write` out 1, `out_is_load` out 1.

## Operation
- Holds one entry with internal `vld`.
- `in_ready = flush | ~vld | (out_valid & out_ready)`.
- Accept on `in_valid & in_ready & ~flush`. All `in_*` fields are registered and `vld` is set to 1.
- When `out_valid & out_ready` occurs without a new accept, `vld` is cleared.
- `flush` has top priority. It clears `vld` next edge and discards the incoming instruction, even when `in_valid` is high.
- Forwarding applies combinationally to the registered rs1 and rs2 data.
  - EX/MEM wins when `exm_reg_write & exm_rd!=0 & exm_rd==rs`.
  - Otherwise MEM/WB is used under the same rule.
  - Otherwise the registered data is used.
  - Index 0 is never forwarded.
- `out_a` is forwarded rs1.
- `out_b` is `alu_src ? imm : forwarded rs2`.
- `out_store_data` is always forwarded rs2.
- Load-use hold: `ldh = exm_is_load & exm_reg_write & exm_rd!=0 & (exm_rd==rs1 | (~alu_src & exm_rd==rs2))`.
- `out_valid = vld & ~ldh`. While the hold is active, the entry stays in place and `in_ready` is 0 (unless `flush`).
- Control outputs (`out_alu_cntrl`, `out_rd`, `out_reg_write`, `out_is_load`) are registered fields, gated to 0 when `~vld`.
- No arithmetic is done in this block. Widths pass through unchanged.

## Timing
- Reset (async, `rst_n=0`): `vld=0` and every stored field is 0. Consequently:
  - `out_valid`, `out_a`, `out_b`, `out_store_data`, `out_alu_cntrl`, `out_rd`, `out_reg_write` and `out_is_load` are all 0.
  - `in_ready` is 1.
- Reset deassertion is synchronised externally.
- Latency: an instruction accepted at edge N is visible on outputs after edge N. `out_valid` is high in cycle N+1 unless `ldh`.
- Forward muxes and `ldh` are combinational from the `exm_*`/`mwb_*` ports to the outputs. There is no added cycle.
- Back-to-back accept at full throughput when `out_ready=1`.
- Flush mid-hold or mid-stall: entry squashed next edge and `out_valid` goes 0 in the following cycle.
- Reset mid-operation: entry lost immediately and outputs go 0 asynchronously.

## Configuration
- `ID_EX_FORWARD_EN` defined: forwarding and load-use hold as above.
- `ID_EX_FORWARD_EN` undefined:
  - Forward muxes are removed and operands come straight from the registered data.
  - Any RAW match against `exm_*` or `mwb_*` (`reg_write`, nonzero `rd`, matching rs1, or rs2 when `~alu_src` or for store data) holds `out_valid` low until the match clears.
  - `exm_result` and `mwb_result` are unused.

## Structure
- Shared package `riscv_pkg` holds:
  - `alu_op_e`: `ADD=3'b000`, `SUB=3'b001`, `AND=3'b100`, `OR=3'b110`.
  - `fwd_sel_e`: `FWD_REG`, `FWD_MWB`, `FWD_EXM`.
  - `REG_AW`.
  - `id_ex_t`, a packed struct of the stored fields.
- One sub-module, `forward_mux`, instantiated twice (rs1 and rs2). It outputs the selected value and `fwd_sel_e`.

## Test plan
- Reset with `in_valid=1`: all outputs 0 and `in_ready=1` while `rst_n=0`. The first accept occurs on the first edge after release.
- Accept ADD with `rs1_data=5`, `imm=7`, `alu_src=1`, `out_ready=1`: next cycle `out_valid=1`, `out_a=5`, `out_b=7`, `out_alu_cntrl=000`.
- Forward priority with `exm_rd=mwb_rd=rs1=3`, `exm_result=0xAA`, `mwb_result=0xBB`: `out_a=0xAA`. Repeat with `rs1=0`: registered value is used.
- Load-use: held instruction with `rs2=4`, `alu_src=0`, `exm_is_load=1`, `exm_rd=4` for one cycle: `out_valid=0` and `in_ready=0` for that cycle, then `out_valid=1` with `out_b` forwarded from `mwb_result`.
- Flush while `vld=1` and `in_valid=1`: next cycle `out_valid=0`, and the incoming instruction never appears.
- `out_ready=0` for 3 cycles with `in_valid=1`: outputs stable, `in_ready=0`. On `out_ready=1`, the queued instruction appears the next cycle.
